// File: rtl/dmem_pkg.sv
// Shared MMIO map, status-word field positions and region decode type
// for the data-side responder.
package dmem_pkg;

  localparam logic [31:0] LOG_ADR_DEF    = 32'hFFFF_FF00;
  localparam logic [31:0] TOHOST_ADR_DEF = 32'hFFFF_FF04;
  localparam logic [31:0] STAT_ADR_DEF   = 32'hFFFF_FF08;
  localparam logic [31:0] WATCH_ADR_DEF  = 32'd132;
  localparam logic [31:0] WATCH_DATA_DEF = 32'hABCDE02E;

  localparam int STAT_OVF_BIT   = 15;
  localparam int STAT_DONE_BIT  = 14;
  localparam int STAT_PASS_BIT  = 13;
  localparam int STAT_WATCH_BIT = 12;
  localparam int STAT_CNT_LSB   = 4;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_LOG,
    REG_TOHOST,
    REG_STAT,
    REG_NONE
  } region_e;

endpackage

// File: rtl/dmem_responder_log_fifo.sv
// Circular log FIFO with synchronous push/pop and occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module log_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer widths equal log2(DEPTH), so wrap is the natural rollover.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Store-port responder: word RAM plus MMIO log FIFO, tohost status,
// store watchpoint and a free-running store counter.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          RAM_WORDS  = 64,
  parameter int          LOG_DEPTH  = 4,
  parameter logic [31:0] LOG_ADR    = LOG_ADR_DEF,
  parameter logic [31:0] TOHOST_ADR = TOHOST_ADR_DEF,
  parameter logic [31:0] STAT_ADR   = STAT_ADR_DEF,
  parameter logic [31:0] WATCH_ADR  = WATCH_ADR_DEF,
  parameter logic [31:0] WATCH_DATA = WATCH_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] log_data,
  output logic        log_valid,
  input  logic        log_ready,
  output logic        done,
  output logic        pass,
  output logic [30:0] fail_code,
  output logic        watch_hit,
  output logic [31:0] store_cnt
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(LOG_DEPTH) + 1;

  logic [31:0]   r_ram [RAM_WORDS];
  logic          r_overflow;
  logic          r_done;
  logic          r_pass;
  logic [30:0]   r_fail_code;
  logic          r_watch_hit;
  logic [31:0]   r_store_cnt;

  region_e       w_region;
  logic [AW-1:0] w_ram_idx;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [31:0]   w_stat;

  assign w_ram_idx = DataAdr[AW+1:2];

  always_comb begin
    w_region = REG_NONE;
    if (DataAdr < 32'(RAM_WORDS * 4)) w_region = REG_RAM;
    else if (DataAdr == LOG_ADR)      w_region = REG_LOG;
    else if (DataAdr == TOHOST_ADR)   w_region = REG_TOHOST;
    else if (DataAdr == STAT_ADR)     w_region = REG_STAT;
  end

  assign w_push = MemWrite & (w_region == REG_LOG);
  assign w_pop  = log_valid & log_ready;

  log_fifo #(.DEPTH(LOG_DEPTH), .W(32)) u_log_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (WriteData),
    .o_data  (log_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign log_valid = ~w_empty;

  always_comb begin
    w_stat                 = '0;
    w_stat[STAT_OVF_BIT]   = r_overflow;
    w_stat[STAT_DONE_BIT]  = r_done;
    w_stat[STAT_PASS_BIT]  = r_pass;
    w_stat[STAT_WATCH_BIT] = r_watch_hit;
    w_stat[STAT_CNT_LSB +: 8] = 8'(w_count);
  end

  always_comb begin
    ReadData = '0;
    case (w_region)
      REG_RAM:  ReadData = r_ram[w_ram_idx];
      REG_STAT: ReadData = w_stat;
      default:  ReadData = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (MemWrite && w_region == REG_RAM) r_ram[w_ram_idx] <= WriteData;
  end

  // Only the first nonzero tohost value is latched; zero writes are no-ops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_code <= '0;
      r_watch_hit <= 1'b0;
      r_store_cnt <= '0;
    end else if (MemWrite) begin
      r_store_cnt <= r_store_cnt + 32'd1;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      if (DataAdr == WATCH_ADR && WriteData == WATCH_DATA) r_watch_hit <= 1'b1;
      if (w_region == REG_TOHOST && !r_done && WriteData != 32'd0) begin
        r_done      <= 1'b1;
        r_pass      <= (WriteData == 32'd1);
        r_fail_code <= (WriteData == 32'd1) ? 31'd0 : WriteData[31:1];
      end
    end
  end

  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_code = r_fail_code;
  assign watch_hit = r_watch_hit;
  assign store_cnt = r_store_cnt;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, watchpoint, log FIFO, tohost
// and asynchronous reset, checked against hand-computed values.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [31:0] log_data;
  logic        log_valid;
  logic        log_ready;
  logic        done;
  logic        pass;
  logic [30:0] fail_code;
  logic        watch_hit;
  logic [31:0] store_cnt;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] LOG_A    = 32'hFFFF_FF00;
  localparam logic [31:0] TOHOST_A = 32'hFFFF_FF04;
  localparam logic [31:0] STAT_A   = 32'hFFFF_FF08;

  dmem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .log_data  (log_data),
    .log_valid (log_valid),
    .log_ready (log_ready),
    .done      (done),
    .pass      (pass),
    .fail_code (fail_code),
    .watch_hit (watch_hit),
    .store_cnt (store_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one store across a posedge; returns 1 time unit after the edge.
  task automatic store(input logic [31:0] adr, input logic [31:0] data);
    MemWrite  = 1'b1;
    DataAdr   = adr;
    WriteData = data;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  task automatic load(input logic [31:0] adr, output logic [31:0] data);
    DataAdr = adr;
    #1;
    data = ReadData;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;

  initial begin
    reset     = 1'b1;
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
    log_ready = 1'b0;
    #22;
    check("rst_log_valid", {31'd0, log_valid}, 32'd0);
    check("rst_done",      {31'd0, done},      32'd0);
    check("rst_watch",     {31'd0, watch_hit}, 32'd0);
    check("rst_store_cnt", store_cnt,          32'd0);
    load(STAT_A, rd);
    check("rst_stat",      rd,                 32'd0);
    reset = 1'b0;
    tick();

    // RAM write / same-cycle load
    store(32'h10, 32'h1234_5678);
    load(32'h10, rd);
    check("ram_load",      rd,        32'h1234_5678);
    check("cnt_after_1",   store_cnt, 32'd1);

    // Watchpoint: near-miss data, then exact match
    store(32'd132, 32'hABCD_E02F);
    check("watch_miss",    {31'd0, watch_hit}, 32'd0);
    store(32'd132, 32'hABCD_E02E);
    check("watch_hit",     {31'd0, watch_hit}, 32'd1);
    load(32'd132, rd);
    check("ram_132",       rd,        32'hABCD_E02E);
    store(32'h0000_1000, 32'hDEAD_BEEF);
    check("cnt_unmapped",  store_cnt, 32'd4);
    load(32'h0000_1000, rd);
    check("load_unmapped", rd,        32'd0);
    load(TOHOST_A, rd);
    check("load_tohost",   rd,        32'd0);

    // Log FIFO: fill past capacity with consumer stalled
    store(LOG_A, 32'd0);
    check("push_latency_v", {31'd0, log_valid}, 32'd1);
    check("push_latency_d", log_data,           32'd0);
    for (int i = 1; i < 4; i++) store(LOG_A, 32'(i));
    load(STAT_A, rd);
    check("stat_full",     rd, 32'h0000_1040);
    store(LOG_A, 32'd4);
    load(STAT_A, rd);
    check("stat_overflow", rd, 32'h0000_9040);
    log_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", {31'd0, log_valid}, 32'd1);
      check("drain_data",  log_data,           32'(i));
      tick();
    end
    check("drain_empty",   {31'd0, log_valid}, 32'd0);
    log_ready = 1'b0;

    // Full FIFO with simultaneous push and pop
    for (int i = 5; i < 9; i++) store(LOG_A, 32'(i));
    log_ready = 1'b1;
    store(LOG_A, 32'd9);
    log_ready = 1'b0;
    load(STAT_A, rd);
    check("pushpop_stat",  rd,        32'h0000_9040);
    check("pushpop_head",  log_data,  32'd6);
    log_ready = 1'b1;
    for (int i = 6; i < 10; i++) begin
      check("drain2_data", log_data, 32'(i));
      tick();
    end
    check("drain2_empty",  {31'd0, log_valid}, 32'd0);
    log_ready = 1'b0;
    check("cnt_after_log", store_cnt, 32'd14);

    // Tohost: failing code latches, later writes ignored
    store(TOHOST_A, 32'd7);
    check("th7_done",  {31'd0, done},      32'd1);
    check("th7_pass",  {31'd0, pass},      32'd0);
    check("th7_code",  {1'b0, fail_code},  32'd3);
    store(TOHOST_A, 32'd1);
    check("th1_pass",  {31'd0, pass},      32'd0);
    check("th1_code",  {1'b0, fail_code},  32'd3);

    // Fresh run: zero write is a no-op, then pass
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    store(TOHOST_A, 32'd0);
    check("th0_done",  {31'd0, done},      32'd0);
    store(TOHOST_A, 32'd1);
    check("thp_done",  {31'd0, done},      32'd1);
    check("thp_pass",  {31'd0, pass},      32'd1);
    check("thp_code",  {1'b0, fail_code},  32'd0);
    load(STAT_A, rd);
    check("thp_stat",  rd,                 32'h0000_6000);

    // Async reset mid-drain
    for (int i = 0; i < 4; i++) store(LOG_A, 32'h100 + 32'(i));
    log_ready = 1'b1;
    tick();
    check("mid_head",  log_data,  32'h101);
    #2 reset = 1'b1;
    #1;
    check("ar_valid",  {31'd0, log_valid}, 32'd0);
    check("ar_cnt",    store_cnt,          32'd0);
    check("ar_done",   {31'd0, done},      32'd0);
    check("ar_pass",   {31'd0, pass},      32'd0);
    load(STAT_A, rd);
    check("ar_stat",   rd,                 32'd0);
    log_ready = 1'b0;
    reset = 1'b0;
    tick();
    check("post_valid", {31'd0, log_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
